windowed_register_file: RTL and testbench

Parametrised SPARC-style windowed register file that generalises the fixed 32×32 flat file of the integer datapath. It provides 8 global registers plus NWINDOWS overlapping windows of 16 registers each. A current-window pointer (CWP) and a window-invalid mask (WIM) are kept internally. The block executes SAVE/RESTORE window rotation and raises overflow/underflow trap pulses toward the trap controller. It sits between the decode stage (read addresses) and the writeback stage (write port), in place of the flat register file.

---
 rtl/windowed_register_file_if.sv | 37 +++
 rtl/windowed_register_file.sv | 89 ++++++++
 tb/tb_windowed_register_file.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/windowed_register_file_if.sv
// Bus bundle for windowed_register_file: decode-stage read ports, writeback write port,
// window control requests and trap/status outputs.
interface windowed_register_file_if #(
    parameter int WIDTH    = 32,
    parameter int NWINDOWS = 8,
    parameter int CWPW     = $clog2(NWINDOWS)
);
    logic [4:0]          MuxA;
    logic [4:0]          MuxB;
    logic [WIDTH-1:0]    PA;
    logic [WIDTH-1:0]    PB;
    logic                RFLd;
    logic [4:0]          InDecoder;
    logic [WIDTH-1:0]    InRegister;
    logic                save;
    logic                restore;
    logic                cwp_ld;
    logic [CWPW-1:0]     cwp_in;
    logic                wim_ld;
    logic [NWINDOWS-1:0] wim_in;
    logic [CWPW-1:0]     cwp;
    logic [NWINDOWS-1:0] wim;
    logic                ovf_trap;
    logic                unf_trap;

    modport master (
        output MuxA, MuxB, RFLd, InDecoder, InRegister,
        output save, restore, cwp_ld, cwp_in, wim_ld, wim_in,
        input  PA, PB, cwp, wim, ovf_trap, unf_trap
    );

    modport slave (
        input  MuxA, MuxB, RFLd, InDecoder, InRegister,
        input  save, restore, cwp_ld, cwp_in, wim_ld, wim_in,
        output PA, PB, cwp, wim, ovf_trap, unf_trap
    );
endinterface

// File: rtl/windowed_register_file.sv
// SPARC-style windowed register file: 8 globals + NWINDOWS overlapping 16-register windows,
// CWP/WIM state, SAVE/RESTORE rotation with overflow/underflow traps. Option macro: RF_BYPASS_EN.
module windowed_register_file #(
    parameter int WIDTH    = 32,
    parameter int NWINDOWS = 8,
    parameter int CWPW     = $clog2(NWINDOWS)
) (
    input  logic                    clk,
    input  logic                    reset,
    windowed_register_file_if.slave bus
);
    localparam int NPHYS = 8 + 16 * NWINDOWS;
    localparam int PIW   = $clog2(NPHYS);
    localparam logic [CWPW-1:0] LAST_WIN = CWPW'(NWINDOWS - 1);

    logic [WIDTH-1:0]    r_mem [NPHYS];
    logic [CWPW-1:0]     r_cwp;
    logic [NWINDOWS-1:0] r_wim;
    logic                r_ovf;
    logic                r_unf;

    logic [PIW-1:0]      w_pa_idx;
    logic [PIW-1:0]      w_pb_idx;
    logic [PIW-1:0]      w_wr_idx;
    logic                w_wr_en;
    logic [CWPW-1:0]     w_cwp_dec;
    logic [CWPW-1:0]     w_cwp_inc;
    logic [WIDTH-1:0]    w_pa;
    logic [WIDTH-1:0]    w_pb;

    // Window offset wraps with a single compare, so NWINDOWS need not be a power of two.
    function automatic logic [PIW-1:0] f_phys(input logic [4:0] addr, input logic [CWPW-1:0] win);
        int off;
        if (addr < 5'd8) return PIW'(addr);
        off = 16 * int'(win) + int'(addr) - 8;
        if (off >= 16 * NWINDOWS) off = off - 16 * NWINDOWS;
        return PIW'(off + 8);
    endfunction

    assign w_pa_idx  = f_phys(bus.MuxA, r_cwp);
    assign w_pb_idx  = f_phys(bus.MuxB, r_cwp);
    assign w_wr_idx  = f_phys(bus.InDecoder, r_cwp);
    assign w_wr_en   = bus.RFLd && (bus.InDecoder != 5'd0);
    assign w_cwp_dec = (r_cwp == '0) ? LAST_WIN : r_cwp - CWPW'(1);
    assign w_cwp_inc = (r_cwp == LAST_WIN) ? '0 : r_cwp + CWPW'(1);

    always_comb begin
        w_pa = '0;
        w_pb = '0;
        if (bus.MuxA != 5'd0) w_pa = r_mem[w_pa_idx];
        if (bus.MuxB != 5'd0) w_pb = r_mem[w_pb_idx];
`ifdef RF_BYPASS_EN
        // r0 maps to index 0 and a nonzero write never does, so r0 cannot be forwarded.
        if (w_wr_en && (w_wr_idx == w_pa_idx)) w_pa = bus.InRegister;
        if (w_wr_en && (w_wr_idx == w_pb_idx)) w_pb = bus.InRegister;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPHYS; i++) r_mem[i] <= '0;
            r_cwp <= '0;
            r_wim <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
            if (w_wr_en) r_mem[w_wr_idx] <= bus.InRegister;
            if (bus.wim_ld) r_wim <= bus.wim_in;
            if (bus.cwp_ld) begin
                r_cwp <= (int'(bus.cwp_in) < NWINDOWS) ? bus.cwp_in : '0;
            end else if (bus.save && !bus.restore) begin
                if (r_wim[w_cwp_dec]) r_ovf <= 1'b1;
                else                  r_cwp <= w_cwp_dec;
            end else if (bus.restore && !bus.save) begin
                if (r_wim[w_cwp_inc]) r_unf <= 1'b1;
                else                  r_cwp <= w_cwp_inc;
            end
        end
    end

    assign bus.PA       = w_pa;
    assign bus.PB       = w_pb;
    assign bus.cwp      = r_cwp;
    assign bus.wim      = r_wim;
    assign bus.ovf_trap = r_ovf;
    assign bus.unf_trap = r_unf;
endmodule

// File: tb/tb_windowed_register_file.sv
// Self-checking bench for windowed_register_file: NWINDOWS=8 and NWINDOWS=5 instances,
// a control-vector table, directed corner sequences and a randomized run against a slot model.
module tb_windowed_register_file;
    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;

    windowed_register_file_if #(.WIDTH(32), .NWINDOWS(8)) ifa ();
    windowed_register_file_if #(.WIDTH(32), .NWINDOWS(5)) ifb ();

    windowed_register_file #(.WIDTH(32), .NWINDOWS(8)) u_a (.clk(clk), .reset(reset_a), .bus(ifa));
    windowed_register_file #(.WIDTH(32), .NWINDOWS(5)) u_b (.clk(clk), .reset(reset_b), .bus(ifb));

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        ifa.MuxA = 5'd0; ifa.MuxB = 5'd0; ifa.RFLd = 1'b0; ifa.InDecoder = 5'd0;
        ifa.InRegister = 32'd0; ifa.save = 1'b0; ifa.restore = 1'b0; ifa.cwp_ld = 1'b0;
        ifa.cwp_in = 3'd0; ifa.wim_ld = 1'b0; ifa.wim_in = 8'd0;
    endtask

    task automatic idle_b();
        ifb.MuxA = 5'd0; ifb.MuxB = 5'd0; ifb.RFLd = 1'b0; ifb.InDecoder = 5'd0;
        ifb.InRegister = 32'd0; ifb.save = 1'b0; ifb.restore = 1'b0; ifb.cwp_ld = 1'b0;
        ifb.cwp_in = 3'd0; ifb.wim_ld = 1'b0; ifb.wim_in = 5'd0;
    endtask

    // Model: each architectural register resolves to a named storage slot.
    // Globals, per-window outs and locals are distinct slots; ins of w are the outs of w+1.
    logic [31:0] m_mem [int];
    int          m_cwp;
    logic [7:0]  m_wim;

    function automatic int slot(input int a, input int w);
        if (a < 8)  return a;
        if (a < 16) return 100 + w * 8 + (a - 8);
        if (a < 24) return 1000 + w * 8 + (a - 16);
        return 100 + ((w + 1) % 8) * 8 + (a - 24);
    endfunction

    function automatic logic [31:0] m_rd(input int a, input int w);
        int s;
        if (a == 0) return 32'd0;
        s = slot(a, w);
        if (m_mem.exists(s)) return m_mem[s];
        return 32'd0;
    endfunction

    typedef struct {
        logic       sv, rs, ld;
        logic [2:0] cin;
        logic       wl;
        logic [4:0] win;
        logic [2:0] ecwp;
        logic [4:0] ewim;
        logic       eovf, eunf;
    } vec_t;

    vec_t vt [19];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        sv, rs, ld, wl, rf;
        logic [2:0]  cin;
        logic [7:0]  win;
        logic [4:0]  wa, ra, rb;
        logic [31:0] wd, epa, epb;
        logic        eovf, eunf;
        int          d;

        // NWINDOWS=5 control table, applied from reset (cwp=0, wim=0)
        //          sv    rs    ld    cin   wl    win       cwp   wim       ovf   unf
        vt[0]  = '{1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 5'b00000, 3'd4, 5'b00000, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd0, 5'b00000, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd4, 5'b00000, 1'b0, 1'b0};
        vt[3]  = '{1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd4, 5'b00000, 1'b0, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 5'b00000, 3'd0, 5'b00000, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 5'b10000, 3'd0, 5'b10000, 1'b0, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd0, 5'b10000, 1'b1, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd0, 5'b10000, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd1, 5'b10000, 1'b0, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd2, 5'b10000, 1'b0, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 5'b01000, 3'd3, 5'b01000, 1'b0, 1'b0};
        vt[11] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd4, 5'b01000, 1'b0, 1'b0};
        vt[12] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd0, 5'b01000, 1'b0, 1'b0};
        vt[13] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd4, 5'b01000, 1'b0, 1'b0};
        vt[14] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd4, 5'b01000, 1'b1, 1'b0};
        vt[15] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 5'b00001, 3'd4, 5'b00001, 1'b0, 1'b0};
        vt[16] = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd4, 5'b00001, 1'b0, 1'b1};
        vt[17] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 5'b00000, 3'd4, 5'b00001, 1'b0, 1'b0};
        vt[18] = '{1'b0, 1'b0, 1'b1, 3'd7, 1'b0, 5'b00000, 3'd0, 5'b00001, 1'b0, 1'b0};

        idle_a();
        idle_b();
        reset_a = 1'b1;
        reset_b = 1'b1;
        tick();
        tick();
        reset_a = 1'b0;
        reset_b = 1'b0;
        ifa.MuxA = 5'd5;
        #1;
        chk("reset_cwp", 32'(ifa.cwp), 32'd0);
        chk("reset_wim", 32'(ifa.wim), 32'd0);
        chk("reset_ovf", 32'(ifa.ovf_trap), 32'd0);
        chk("reset_unf", 32'(ifa.unf_trap), 32'd0);
        chk("reset_pa_r5", ifa.PA, 32'd0);

        // Table on NWINDOWS=5
        for (int i = 0; i < 19; i++) begin
            ifb.save = vt[i].sv; ifb.restore = vt[i].rs; ifb.cwp_ld = vt[i].ld;
            ifb.cwp_in = vt[i].cin; ifb.wim_ld = vt[i].wl; ifb.wim_in = vt[i].win;
            tick();
            chk($sformatf("vec%0d_cwp", i), 32'(ifb.cwp), 32'(vt[i].ecwp));
            chk($sformatf("vec%0d_wim", i), 32'(ifb.wim), 32'(vt[i].ewim));
            chk($sformatf("vec%0d_ovf", i), 32'(ifb.ovf_trap), 32'(vt[i].eovf));
            chk($sformatf("vec%0d_unf", i), 32'(ifb.unf_trap), 32'(vt[i].eunf));
        end
        idle_b();

        // Globals and r0
        ifa.RFLd = 1'b1; ifa.InDecoder = 5'd5; ifa.InRegister = 32'hDEADBEEF;
        tick();
        ifa.InDecoder = 5'd0;
        tick();
        idle_a();
        ifa.MuxA = 5'd5; ifa.MuxB = 5'd0;
        #1;
        chk("r5_read", ifa.PA, 32'hDEADBEEF);
        chk("r0_read", ifa.PB, 32'd0);

        // Out/in aliasing across a SAVE
        ifa.cwp_ld = 1'b1; ifa.cwp_in = 3'd3;
        tick();
        idle_a();
        chk("alias_cwp3", 32'(ifa.cwp), 32'd3);
        ifa.RFLd = 1'b1; ifa.InDecoder = 5'd9; ifa.InRegister = 32'h11;
        tick();
        idle_a();
        ifa.save = 1'b1;
        tick();
        idle_a();
        chk("alias_cwp2", 32'(ifa.cwp), 32'd2);
        ifa.MuxA = 5'd25;
        #1;
        chk("alias_r25", ifa.PA, 32'h11);

        // Overflow trap pulse and recovery
        idle_a();
        ifa.wim_ld = 1'b1; ifa.wim_in = 8'h01; ifa.cwp_ld = 1'b1; ifa.cwp_in = 3'd1;
        tick();
        idle_a();
        ifa.save = 1'b1;
        tick();
        idle_a();
        chk("ovf_pulse", 32'(ifa.ovf_trap), 32'd1);
        chk("ovf_cwp_hold", 32'(ifa.cwp), 32'd1);
        tick();
        chk("ovf_clear", 32'(ifa.ovf_trap), 32'd0);
        ifa.restore = 1'b1;
        tick();
        idle_a();
        chk("restore_cwp2", 32'(ifa.cwp), 32'd2);
        chk("restore_no_unf", 32'(ifa.unf_trap), 32'd0);
        chk("restore_no_ovf", 32'(ifa.ovf_trap), 32'd0);

        // cwp_ld overrides a save that would otherwise trap
        ifa.wim_ld = 1'b1; ifa.wim_in = 8'h02;
        tick();
        idle_a();
        ifa.cwp_ld = 1'b1; ifa.cwp_in = 3'd6; ifa.save = 1'b1;
        tick();
        idle_a();
        chk("ld_cwp6", 32'(ifa.cwp), 32'd6);
        chk("ld_no_ovf", 32'(ifa.ovf_trap), 32'd0);

        // Same-cycle write/read of r20
        ifa.RFLd = 1'b1; ifa.InDecoder = 5'd20; ifa.InRegister = 32'hCAFE; ifa.MuxA = 5'd20;
        #1;
`ifdef RF_BYPASS_EN
        chk("r20_same_cycle", ifa.PA, 32'hCAFE);
`else
        chk("r20_same_cycle", ifa.PA, 32'd0);
`endif
        tick();
        ifa.RFLd = 1'b0;
        #1;
        chk("r20_next_cycle", ifa.PA, 32'hCAFE);

        // Reset wins over a trapping save on the same edge
        idle_a();
        ifa.wim_ld = 1'b1; ifa.wim_in = 8'h20;
        tick();
        idle_a();
        ifa.save = 1'b1;
        reset_a = 1'b1;
        tick();
        reset_a = 1'b0;
        idle_a();
        ifa.MuxA = 5'd20;
        ifa.MuxB = 5'd5;
        #1;
        chk("rst_mid_cwp", 32'(ifa.cwp), 32'd0);
        chk("rst_mid_wim", 32'(ifa.wim), 32'd0);
        chk("rst_mid_ovf", 32'(ifa.ovf_trap), 32'd0);
        chk("rst_mid_r5", ifa.PB, 32'd0);
        tick();
        chk("rst_mid_ovf_after", 32'(ifa.ovf_trap), 32'd0);

        // Randomized run on NWINDOWS=8 from the reset state
        m_mem.delete();
        m_cwp = 0;
        m_wim = 8'd0;
        for (int i = 0; i < 500; i++) begin
            sv  = ($urandom_range(0, 2) == 0);
            rs  = ($urandom_range(0, 2) == 0);
            ld  = ($urandom_range(0, 15) == 0);
            cin = 3'($urandom_range(0, 7));
            wl  = ($urandom_range(0, 7) == 0);
            win = 8'($urandom & $urandom);
            rf  = ($urandom_range(0, 1) == 0);
            wa  = 5'($urandom_range(0, 31));
            ra  = 5'($urandom_range(0, 31));
            rb  = (i % 4 == 0) ? wa : 5'($urandom_range(0, 31));
            wd  = $urandom;
            ifa.save = sv; ifa.restore = rs; ifa.cwp_ld = ld; ifa.cwp_in = cin;
            ifa.wim_ld = wl; ifa.wim_in = win; ifa.RFLd = rf; ifa.InDecoder = wa;
            ifa.InRegister = wd; ifa.MuxA = ra; ifa.MuxB = rb;
            #1;
            epa = m_rd(int'(ra), m_cwp);
            epb = m_rd(int'(rb), m_cwp);
`ifdef RF_BYPASS_EN
            if (rf && wa != 5'd0 && slot(int'(wa), m_cwp) == slot(int'(ra), m_cwp)) epa = wd;
            if (rf && wa != 5'd0 && slot(int'(wa), m_cwp) == slot(int'(rb), m_cwp)) epb = wd;
`endif
            chk($sformatf("rnd%0d_pa", i), ifa.PA, epa);
            chk($sformatf("rnd%0d_pb", i), ifa.PB, epb);
            tick();
            if (rf && wa != 5'd0) m_mem[slot(int'(wa), m_cwp)] = wd;
            eovf = 1'b0;
            eunf = 1'b0;
            if (ld) begin
                m_cwp = int'(cin);
            end else if (sv && !rs) begin
                d = (m_cwp + 7) % 8;
                if (m_wim[d]) eovf = 1'b1;
                else          m_cwp = d;
            end else if (rs && !sv) begin
                d = (m_cwp + 1) % 8;
                if (m_wim[d]) eunf = 1'b1;
                else          m_cwp = d;
            end
            if (wl) m_wim = win;
            chk($sformatf("rnd%0d_cwp", i), 32'(ifa.cwp), 32'(m_cwp));
            chk($sformatf("rnd%0d_wim", i), 32'(ifa.wim), 32'(m_wim));
            chk($sformatf("rnd%0d_ovf", i), 32'(ifa.ovf_trap), 32'(eovf));
            chk($sformatf("rnd%0d_unf", i), 32'(ifa.unf_trap), 32'(eunf));
        end
        idle_a();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
